counter_updn_mod: RTL and testbench
===================================

# counter_updn_mod

Parametrised synchronous presettable counter, the next generation of the team's 4-bit 74LVC161-style counter. It adds:
- configurable width and modulus
- up/down direction
- a saturate (stop-at-terminal) mode
- a registered carry pulse for cascading

It keeps the 161 control set (active-low clear and load, CEP/CET enables, TC), so it can replace the existing counter in cascaded timer and divider chains.

## Interface
- WIDTH, 4, counter width in bits (2..32)
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH
- CP  input  1  clock; all state changes on its rising edge
- CR  input  1  reset, asynchronous, active-low; forces Q=0, CO=0
- PE  input  1  parallel load, synchronous, active-low
- CEP  input  1  count enable (parallel)
- CET  input  1  count enable (trickle); also gates TC
- UD  input  1  direction: 1 = up, 0 = down
- SAT  input  1  mode: 0 = wrap, 1 = saturate at terminal value
- D  input  WIDTH  load value
- Q  output  WIDTH  counter state
- TC  output  1  terminal count, combinational
- CO  output  1  registered carry/borrow pulse

## Operation
- Terminal value: MODULUS-1 when UD=1, 0 when UD=0.
- TC = CET & (Q == terminal value).
- Priority on each rising CP edge, highest first:
  1. CR low: asynchronous, overrides everything.
  2. PE low: load.
  3. CEP & CET: count.
  4. Otherwise: hold.
- Load: Q ← D when D < MODULUS; otherwise Q ← MODULUS-1 (clamp). A load clears CO.
- Count, up: Q ← Q+1. At Q = MODULUS-1: Q ← 0 in wrap mode, Q holds in saturate mode.
- Count, down: Q ← Q-1. At Q = 0: Q ← MODULUS-1 in wrap mode, Q holds in saturate mode.
- CO goes high for exactly one cycle after a wrap event, i.e. a counting edge with Q at the terminal value and SAT=0. Otherwise CO is 0.
- Saturate mode never asserts CO. TC stays high while Q is held at the terminal value and CET=1.
- Hold: Q and CO unchanged, except that CO clears to 0 on any non-wrap edge.
- Direction change: UD is sampled at each edge. TC follows UD combinationally within the same cycle.
- Out-of-range Q (above MODULUS-1) cannot occur. Arithmetic is WIDTH bits with explicit wrap to the modulus, not natural overflow, unless MODULUS = 2^WIDTH.

## Timing
- Reset values: Q=0, CO=0. TC = CET & ~UD while in reset, because Q=0 is the down terminal.
- CR deassertion takes effect from the next rising CP edge. No counting occurs on an edge where CR is low.
- Load latency is 1 edge: D appears on Q after the edge where PE was sampled low.
- Count latency is 1 edge per step. CEP/CET/UD/SAT/D are setup-sampled at the rising edge.
- TC is combinational from Q, CET and UD, with no register stage.
- CO is registered: high during the cycle following the wrap edge.
- Cascading: stage n+1 has CET = TC of stage n, with common CP. Stage n+1 advances on the same edge that wraps stage n.
- Reset mid-count asserted asynchronously: Q and CO clear immediately, without waiting for CP.

## Structure
- Shared package counter_pkg:
  - direction constants CNT_UP=1, CNT_DN=0
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - a function computing the next state given (Q, UD, SAT, MODULUS)
- One sub-module, counter_term_detect: a combinational terminal-value comparator (Q, UD, CET → TC, at_term), parametrised by WIDTH and MODULUS.
- Top level holds the Q/CO registers and the priority mux.

## Test plan
- Reset/hold: CR=0 with CEP=CET=1 for 5 edges → Q=0, CO=0. Release CR, set CEP=0 for 3 edges → Q stays 0.
- Load and clamp (WIDTH=4, MODULUS=10): PE=0, D=6 → Q=6 next edge. PE=0, D=13 → Q=9.
- Up wrap (MODULUS=10, UD=1, SAT=0):
  - From Q=7, count 3 edges → Q=8,9,0.
  - TC=1 only while Q=9.
  - CO=1 for the single cycle after 9→0.
- Down wrap and saturate:
  - UD=0, SAT=0, from Q=1 → Q=0,9; CO pulses once.
  - UD=0, SAT=1, from Q=1 → Q=0,0,0; CO stays 0; TC stays 1.
- Enable gating and cascade: two 4-bit instances (MODULUS=16), stage 1 CET = stage 0 TC.
  - Count from 0x0E over 3 edges → combined value 0x0E, 0x0F, 0x10, 0x11.
  - Drop CEP → no change.
  - Drop CET of stage 0 → TC=0 and both stages hold.
- Async reset mid-count: assert CR low between edges with Q=5 → Q=0 immediately (before the next CP edge). After release, the first counting edge gives Q=1.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and next-state function for the up/down counter
package counter_pkg;

    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Next counting value with explicit wrap to the modulus (never natural overflow)
    function automatic logic [63:0] next_count(
        input logic [63:0] q,
        input logic        ud,
        input logic        sat,
        input logic [63:0] modulus
    );
        logic [63:0] r;
        if (ud == CNT_UP) begin
            if (q == modulus - 64'd1) r = (sat == MODE_SAT) ? q : 64'd0;
            else                      r = q + 64'd1;
        end else begin
            if (q == 64'd0)           r = (sat == MODE_SAT) ? q : modulus - 64'd1;
            else                      r = q - 64'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_updn_mod_if.sv
// rtl/counter_updn_mod_if.sv - control/status bundle of the up/down counter
interface counter_updn_mod_if #(
    parameter int WIDTH = 4
) ();
    logic             PE;
    logic             CEP;
    logic             CET;
    logic             UD;
    logic             SAT;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             CO;

    modport master (output PE, CEP, CET, UD, SAT, D, input  Q, TC, CO);
    modport slave  (input  PE, CEP, CET, UD, SAT, D, output Q, TC, CO);
endinterface

// File: rtl/counter_term_detect.sv
// rtl/counter_term_detect.sv - combinational terminal-value comparator
module counter_term_detect
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_ud,
    input  logic             i_cet,
    output logic             o_tc,
    output logic             o_at_term
);
    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULUS - 64'd1);

    logic w_at_term;

    // Terminal is MODULUS-1 counting up and 0 counting down; TC is gated by CET
    always_comb begin
        w_at_term = (i_ud == CNT_UP) ? (i_q == TERM_UP) : (i_q == '0);
        o_at_term = w_at_term;
        o_tc      = i_cet & w_at_term;
    end
endmodule

// File: rtl/counter_updn_mod.sv
// rtl/counter_updn_mod.sv - presettable up/down counter with wrap/saturate and carry pulse
module counter_updn_mod
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic               CP,
    input  logic               CR,
    counter_updn_mod_if.slave  bus
);
    localparam logic [WIDTH-1:0] LOAD_MAX = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;
    logic             w_at_term;
    logic             w_tc;
    logic             w_count;
    logic             w_wrap;

    counter_term_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_term (
        .i_q       (r_q),
        .i_ud      (bus.UD),
        .i_cet     (bus.CET),
        .o_tc      (w_tc),
        .o_at_term (w_at_term)
    );

    // Count step, load clamp and wrap-event detection for the coming edge
    always_comb begin
        w_count = bus.CEP & bus.CET;
        w_wrap  = w_count & w_at_term & (bus.SAT == MODE_WRAP);
        w_next  = WIDTH'(next_count(64'(r_q), bus.UD, bus.SAT, MODULUS));
        w_load  = (64'(bus.D) < MODULUS) ? bus.D : LOAD_MAX;
    end

    // Priority: async clear, then load, then count, otherwise hold; CO is high only after a wrap
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_q  <= '0;
            r_co <= 1'b0;
        end else if (!bus.PE) begin
            r_q  <= w_load;
            r_co <= 1'b0;
        end else if (w_count) begin
            r_q  <= w_next;
            r_co <= w_wrap;
        end else begin
            r_co <= 1'b0;
        end
    end

    assign bus.Q  = r_q;
    assign bus.TC = w_tc;
    assign bus.CO = r_co;
endmodule

// File: tb/tb_counter_updn_mod.sv
// tb/tb_counter_updn_mod.sv - scoreboard bench for counter_updn_mod and a two-stage cascade
module tb_counter_updn_mod;
    localparam int M = 10;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       pe, cep, cet, ud, sat;
    logic [3:0] d;
    logic       c_pe, c_cep, c_cet0;
    logic [7:0] c_d;

    always #5 CP = ~CP;

    counter_updn_mod_if #(.WIDTH(4)) m_if ();
    counter_updn_mod_if #(.WIDTH(4)) c0_if ();
    counter_updn_mod_if #(.WIDTH(4)) c1_if ();

    assign m_if.PE  = pe;
    assign m_if.CEP = cep;
    assign m_if.CET = cet;
    assign m_if.UD  = ud;
    assign m_if.SAT = sat;
    assign m_if.D   = d;

    assign c0_if.PE  = c_pe;
    assign c0_if.CEP = c_cep;
    assign c0_if.CET = c_cet0;
    assign c0_if.UD  = 1'b1;
    assign c0_if.SAT = 1'b0;
    assign c0_if.D   = c_d[3:0];
    assign c1_if.PE  = c_pe;
    assign c1_if.CEP = c_cep;
    assign c1_if.CET = c0_if.TC;
    assign c1_if.UD  = 1'b1;
    assign c1_if.SAT = 1'b0;
    assign c1_if.D   = c_d[7:4];

    counter_updn_mod #(.WIDTH(4), .MODULUS(10)) u_dut (.CP(CP), .CR(CR), .bus(m_if));
    counter_updn_mod #(.WIDTH(4), .MODULUS(16)) u_c0  (.CP(CP), .CR(CR), .bus(c0_if));
    counter_updn_mod #(.WIDTH(4), .MODULUS(16)) u_c1  (.CP(CP), .CR(CR), .bus(c1_if));

    typedef struct {
        string name;
        int    q;
        bit    co;
        bit    tc;
        int    cval;
        bit    ctc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mq  = 0;
    bit   mco = 0;
    int   cv  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: advance one edge from the rules, queue the expected outputs, let the edge pass
    task automatic tick(input string name);
        exp_t e;
        bit   term;
        if (!CR) begin
            mq = 0; mco = 0; cv = 0;
        end else begin
            if (!pe) begin
                mq  = (int'(d) < M) ? int'(d) : M - 1;
                mco = 0;
            end else if (cep && cet) begin
                term = ud ? (mq == M - 1) : (mq == 0);
                mco  = term && !sat;
                if (ud) mq = sat ? ((mq + 1 > M - 1) ? M - 1 : mq + 1) : (mq + 1) % M;
                else    mq = sat ? ((mq == 0) ? 0 : mq - 1) : (mq + M - 1) % M;
            end else begin
                mco = 0;
            end
            if (!c_pe)                 cv = int'(c_d);
            else if (c_cep && c_cet0)  cv = (cv + 1) % 256;
        end
        e.name = name;
        e.q    = mq;
        e.co   = mco;
        e.tc   = cet && (ud ? (mq == M - 1) : (mq == 0));
        e.cval = cv;
        e.ctc  = c_cet0 && ((cv % 16) == 15);
        sb.push_back(e);
        @(negedge CP);
    endtask

    task automatic ticks(input string name, input int n);
        for (int i = 0; i < n; i++) tick(name);
    endtask

    // Monitor: compare every presented output against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge CP);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "_q"},    int'(m_if.Q), e.q);
                check({e.name, "_co"},   int'(m_if.CO), int'(e.co));
                check({e.name, "_tc"},   int'(m_if.TC), int'(e.tc));
                check({e.name, "_cval"}, int'({c1_if.Q, c0_if.Q}), e.cval);
                check({e.name, "_ctc"},  int'(c0_if.TC), int'(e.ctc));
            end
        end
    end

    initial begin
        pe = 1; cep = 1; cet = 1; ud = 0; sat = 0; d = 0;
        c_pe = 1; c_cep = 0; c_cet0 = 0; c_d = 0;
        @(negedge CP);
        check("rst_q",  int'(m_if.Q), 0);
        check("rst_co", int'(m_if.CO), 0);
        check("rst_tc", int'(m_if.TC), 1);
        ticks("reset", 5);

        CR = 1; cep = 0;
        ticks("hold", 3);

        pe = 0; d = 6;  tick("load6");
        d = 13;         tick("clamp");
        d = 7;          tick("load7");
        pe = 1; cep = 1; ud = 1; sat = 0;
        ticks("up_wrap", 4);

        pe = 0; d = 1;  tick("load1");
        pe = 1; ud = 0;
        ticks("dn_wrap", 3);

        pe = 0; d = 1;  tick("load1s");
        pe = 1; sat = 1;
        ticks("dn_sat", 3);

        pe = 0; d = 8;  ud = 1; tick("load8");
        pe = 1;
        ticks("up_sat", 3);
        cet = 0;
        ticks("cet_off", 2);
        cet = 1; sat = 0; cep = 0;

        c_pe = 0; c_d = 8'h0E; tick("c_load");
        c_pe = 1; c_cep = 1; c_cet0 = 1;
        ticks("c_count", 3);
        c_cep = 0;
        ticks("c_cep_off", 2);
        c_cep = 1; c_cet0 = 0;
        ticks("c_cet_off", 2);
        c_pe = 0; c_d = 8'h1F; tick("c_load1f");
        c_pe = 1;
        ticks("c_cet_off2", 2);
        c_cet0 = 1;
        tick("c_carry");
        c_pe = 0; c_d = 8'hFF; tick("c_loadff");
        c_pe = 1;
        ticks("c_wrap", 2);

        for (int i = 0; i < 300; i++) begin
            CR     = ($urandom_range(0, 39) != 0);
            pe     = ($urandom_range(0, 7) != 0);
            cep    = ($urandom_range(0, 4) != 0);
            cet    = ($urandom_range(0, 4) != 0);
            ud     = 1'($urandom_range(0, 1));
            sat    = ($urandom_range(0, 3) == 0);
            d      = 4'($urandom_range(0, 15));
            c_pe   = ($urandom_range(0, 15) != 0);
            c_cep  = ($urandom_range(0, 3) != 0);
            c_cet0 = ($urandom_range(0, 3) != 0);
            c_d    = 8'($urandom_range(0, 255));
            tick("rand");
        end

        CR = 1; pe = 0; d = 5; cep = 0; cet = 1; ud = 1; sat = 0;
        c_pe = 1; c_cep = 0; c_cet0 = 0;
        tick("load5");
        pe = 1; cep = 1;
        #2;
        CR = 0;
        #1;
        check("async_q",  int'(m_if.Q), 0);
        check("async_co", int'(m_if.CO), 0);
        mq = 0; mco = 0; cv = 0;
        @(negedge CP);
        tick("rst_edge");
        CR = 1;
        tick("first_count");

        @(posedge CP);
        #2;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
